// File: rtl/hsvtorgb.sv
// hsvtorgb: one-pixel-per-transaction HSV -> RGB converter, Q16.16 channels.
// Sequence: IDLE accept -> SECT (sector/remainder) -> DIV (16-step restoring
// divide rem/60.0) -> MUL1 -> MUL2 (result registered) -> DONE (held until
// Out_Ready). Optional build macro HSV2RGB_ROUND_EN switches every fixed-point
// shift and the divider result from truncation to round-half-up.
//
// state | meaning
// IDLE  | waiting for In_Valid; In_Ready high
// SECT  | pick 60-degree sector, form remainder inside the sector
// DIV   | one quotient bit per cycle, f = rem / 60.0 as Q0.16
// MUL1  | a = S*f, b = S*(1-f), c = S
// MUL2  | p/q/t from V, select by sector into R/G/B
// DONE  | Out_Valid high until Out_Ready
module hsvtorgb #(
  parameter int W   = 32,
  parameter int LAT = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3*W-1:0] In,
  input  logic           In_Valid,
  output logic           In_Ready,
  output logic [W-1:0]   R,
  output logic [W-1:0]   G,
  output logic [W-1:0]   B,
  output logic           Out_Valid,
  input  logic           Out_Ready
);

  typedef enum logic [2:0] {IDLE, SECT, DIV, MUL1, MUL2, DONE} state_t;

  // Cycles outside DIV: SECT, MUL1, MUL2 plus the DONE presentation cycle.
  localparam int             DIV_STEPS = LAT - 4;
  localparam logic [16:0]    ONE       = 17'h10000;
  localparam logic [24:0]    DIVISOR   = 25'h03C0000;
  localparam logic [W-1:0]   H_WRAP    = 32'h01680000;

  state_t state, state_nx;

  logic [24:0] h_q;
  logic [16:0] s_q, v_q;
  logic [2:0]  sector_q;
  logic [24:0] div_r;
  logic [15:0] quo;
  logic [3:0]  cnt;
  logic [16:0] a_q, b_q, c_q;
  logic [16:0] r_q, g_q, b_out_q;

  logic [24:0] h_cond;
  logic [16:0] s_cond, v_cond;
  logic [2:0]  sector_nx;
  logic [24:0] sector_base;
  logic [24:0] div_sh;
  logic        div_ge;
  logic [15:0] f;
  logic [16:0] p, q, t;

  // Product of two <=1.0 Q16.16 values back to Q16.16, saturated at 1.0.
  function automatic logic [16:0] scale(input logic [16:0] x, input logic [16:0] y);
    logic [33:0] prod;
    prod = {17'd0, x} * {17'd0, y};
`ifdef HSV2RGB_ROUND_EN
    prod = prod + 34'h8000;
`endif
    prod = prod >> 16;
    if (prod > 34'h10000) scale = ONE;
    else                  scale = prod[16:0];
  endfunction

  assign In_Ready  = (state == IDLE);
  assign Out_Valid = (state == DONE);
  assign R = {{(W-17){1'b0}}, r_q};
  assign G = {{(W-17){1'b0}}, g_q};
  assign B = {{(W-17){1'b0}}, b_out_q};

  // Input conditioning: hue wraps at 360, saturation/value clamp at 1.0.
  always_comb begin
    h_cond = (In[3*W-1:2*W] >= H_WRAP) ? 25'd0 : In[2*W+24:2*W];
    s_cond = (In[2*W-1:W] > 32'h00010000) ? ONE : In[W+16:W];
    v_cond = (In[W-1:0]   > 32'h00010000) ? ONE : In[16:0];
  end

  // Sector index and its starting hue.
  always_comb begin
    sector_nx   = 3'd0;
    sector_base = 25'd0;
    if      (h_q >= 25'h12C0000) begin sector_nx = 3'd5; sector_base = 25'h12C0000; end
    else if (h_q >= 25'h0F00000) begin sector_nx = 3'd4; sector_base = 25'h0F00000; end
    else if (h_q >= 25'h0B40000) begin sector_nx = 3'd3; sector_base = 25'h0B40000; end
    else if (h_q >= 25'h0780000) begin sector_nx = 3'd2; sector_base = 25'h0780000; end
    else if (h_q >= 25'h03C0000) begin sector_nx = 3'd1; sector_base = 25'h03C0000; end
  end

  // Divider step and final fraction; in MUL1 the step test yields the 17th bit.
  always_comb begin
    div_sh = div_r << 1;
    div_ge = (div_sh >= DIVISOR);
`ifdef HSV2RGB_ROUND_EN
    begin
      logic [16:0] f_sum;
      f_sum = {1'b0, quo} + 17'(div_ge);
      f = f_sum[16] ? 16'hFFFF : f_sum[15:0];
    end
`else
    f = quo;
`endif
  end

  // V-scaled terms used by the sector select.
  always_comb begin
    p = scale(v_q, ONE - c_q);
    q = scale(v_q, ONE - a_q);
    t = scale(v_q, ONE - b_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (In_Valid) state_nx = SECT;
      SECT:    state_nx = DIV;
      DIV:     if (cnt == 4'd0) state_nx = MUL1;
      MUL1:    state_nx = MUL2;
      MUL2:    state_nx = DONE;
      DONE:    if (Out_Ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers, all cleared by reset so no stale result survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q      <= '0;
      s_q      <= '0;
      v_q      <= '0;
      sector_q <= '0;
      div_r    <= '0;
      quo      <= '0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_out_q  <= '0;
    end else begin
      case (state)
        IDLE: if (In_Valid) begin
          h_q <= h_cond;
          s_q <= s_cond;
          v_q <= v_cond;
        end
        SECT: begin
          sector_q <= sector_nx;
          div_r    <= h_q - sector_base;
          quo      <= '0;
          cnt      <= 4'(DIV_STEPS - 1);
        end
        DIV: begin
          div_r <= div_ge ? (div_sh - DIVISOR) : div_sh;
          quo   <= {quo[14:0], div_ge};
          cnt   <= cnt - 4'd1;
        end
        MUL1: begin
          a_q <= scale(s_q, {1'b0, f});
          b_q <= scale(s_q, ONE - {1'b0, f});
          c_q <= s_q;
        end
        MUL2: begin
          case (sector_q)
            3'd0:    begin r_q <= v_q; g_q <= t;   b_out_q <= p;   end
            3'd1:    begin r_q <= q;   g_q <= v_q; b_out_q <= p;   end
            3'd2:    begin r_q <= p;   g_q <= v_q; b_out_q <= t;   end
            3'd3:    begin r_q <= p;   g_q <= q;   b_out_q <= v_q; end
            3'd4:    begin r_q <= t;   g_q <= p;   b_out_q <= v_q; end
            default: begin r_q <= v_q; g_q <= p;   b_out_q <= q;   end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hsvtorgb.sv
// Directed bench for hsvtorgb: hand-computed vectors, latency, throughput,
// backpressure and reset-abort behaviour.
module tb_hsvtorgb;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_out, g_out, b_out;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hsvtorgb #(.W(32), .LAT(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .In        (in_word),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .R         (r_out),
    .G         (g_out),
    .B         (b_out),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one pixel for a single accept edge, then scramble In.
  task automatic send(input logic [31:0] h, input logic [31:0] s, input logic [31:0] v,
                      output int acc_cyc);
    int n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_word  = {h, s, v};
    in_valid = 1'b1;
    tick;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_word  = ~{h, s, v};
  endtask

  // Edges from accept until Out_Valid is seen; 19 edges = cycle 20 with accept as cycle 0.
  task automatic wait_out(input int acc_cyc, output int lat);
    int n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    lat = cyc - acc_cyc;
  endtask

  task automatic pixel(input string tag, input logic [31:0] h, input logic [31:0] s,
                       input logic [31:0] v, input logic [31:0] er, input logic [31:0] eg,
                       input logic [31:0] eb);
    int acc, lat;
    send(h, s, v, acc);
    wait_out(acc, lat);
    check({tag, "_latency"}, lat, 32'd19);
    check({tag, "_r"}, r_out, er);
    check({tag, "_g"}, g_out, eg);
    check({tag, "_b"}, b_out, eb);
    out_ready = 1'b1;
    tick;
    check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, n_valid, n_acc, acc0, acc1;
    logic pre_ready;

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_word   = {32'h001E0000, 32'h00010000, 32'h00010000};
    out_ready = 1'b0;
    tick; tick; tick;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_rgb", r_out | g_out | b_out, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    //       tag        H             S             V             R             G             B
    pixel("grey",     32'h00000000, 32'h00000000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    pixel("h120",     32'h00780000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00010000, 32'h00000000);
    pixel("h30",      32'h001E0000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00008000, 32'h00000000);
    pixel("h240",     32'h00F00000, 32'h00008000, 32'h00010000, 32'h00008000, 32'h00008000, 32'h00010000);
    pixel("h360",     32'h01680000, 32'h00008000, 32'h00010000, 32'h00010000, 32'h00008000, 32'h00008000);
    pixel("h0",       32'h00000000, 32'h00008000, 32'h00010000, 32'h00010000, 32'h00008000, 32'h00008000);
    pixel("h90",      32'h005A0000, 32'h00010000, 32'h00010000, 32'h00008000, 32'h00010000, 32'h00000000);
    pixel("h200",     32'h00C80000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h0000AAAB, 32'h00010000);
    pixel("h330",     32'h014A0000, 32'h00008000, 32'h00008000, 32'h00008000, 32'h00004000, 32'h00006000);
    pixel("h_max",    32'h0167FFFF, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001);
    pixel("h60",      32'h003C0000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00000000);
    pixel("clamp_sv", 32'h00000000, 32'h00020000, 32'h00030000, 32'h00010000, 32'h00000000, 32'h00000000);

    // Backpressure: result and handshakes frozen while Out_Ready is low.
    send(32'h001E0000, 32'h00010000, 32'h00010000, acc);
    wait_out(acc, lat);
    check("bp_latency", lat, 32'd19);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_g", g_out, 32'h00008000);
    end
    check("bp_r", r_out, 32'h00010000);
    check("bp_b", b_out, 32'h00000000);
    out_ready = 1'b1;
    tick;
    check("bp_release_ov", {31'd0, out_valid}, 32'd0);
    check("bp_release_ir", {31'd0, in_ready}, 32'd1);

    // Back-to-back throughput with both sides always willing.
    in_word  = {32'h00780000, 32'h00010000, 32'h00010000};
    in_valid = 1'b1;
    n_acc = 0; acc0 = 0; acc1 = 0;
    for (int i = 0; i < 50; i++) begin
      pre_ready = in_ready;
      tick;
      if (pre_ready) begin
        if (n_acc == 0) acc0 = cyc;
        else if (n_acc == 1) acc1 = cyc;
        n_acc++;
      end
      if (out_valid) check("tp_g", g_out, 32'h00010000);
    end
    in_valid = 1'b0;
    check("tp_accepts", (n_acc >= 2) ? 32'd1 : 32'd0, 32'd1);
    check("tp_spacing", acc1 - acc0, 32'd21);
    for (int i = 0; i < 30 && !(in_ready && !out_valid); i++) tick;
    check("tp_drained", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Reset at cycle 10 of a conversion aborts it.
    send(32'h00780000, 32'h00010000, 32'h00010000, acc);
    for (int i = 0; i < 9; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_rgb", r_out | g_out | b_out, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    n_valid = 0;
    for (int i = 0; i < 30; i++) begin tick; if (out_valid) n_valid++; end
    check("abort_no_stale", n_valid, 32'd0);

    // Reset while a result is waiting discards it.
    send(32'h001E0000, 32'h00010000, 32'h00010000, acc);
    wait_out(acc, lat);
    check("discard_latency", lat, 32'd19);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("discard_out_valid", {31'd0, out_valid}, 32'd0);
    check("discard_rgb", r_out | g_out | b_out, 32'd0);
    n_valid = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin tick; if (out_valid) n_valid++; end
    check("discard_no_stale", n_valid, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
